sdram_cmd_seq: RTL and testbench
================================

SDRAM_CMD_SEQ -- requirements
Module: sdram_cmd_seq

Interface
REQ-001 Clk_i  input  1  system clock; all state changes on rising edge.
REQ-002 Rst_i  input  1  reset; asynchronous, active-high.
REQ-003 Act_st  input  3  registered command request: 000 none, 100 read/write access, 101 load mode, 110 precharge all, 111 auto refresh; 0xx with [2]=0 means none.
REQ-004 write_st  input  1  access direction, sampled with Act_st=100: 1 write, 0 read.
REQ-005 Add_reg  input  32  latched host address: bank=[21:20], row=[19:8], col=[7:0]; mode word=[11:0].
REQ-006 rcd_c_max, cas_lat_max  input  2 each  tRCD/tRP and CAS latency in cycles; 0 treated as 1.
REQ-007 burst_max  input  3  burst length minus one (1..8 words).
REQ-008 ki_max  input  4  post-refresh wait (tRC) in cycles; 0 treated as 1.
REQ-009 ref_max  input  16  refresh interval in cycles; 0 disables the refresh timer.
REQ-010 sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n  output  1 each  SDRAM command pins, registered.
REQ-011 sd_ba  output  2; sd_a  output  12  bank and address pins, registered.
REQ-012 sd_doe  output  1  write-data drive enable; rd_valid  output  1  read word present on DQ.
REQ-013 busy  output  1  sequencer not accepting; cmd_drop  output  1  one-cycle pulse when a request is discarded.

Function
REQ-014 Command encoding {cs_n,ras_n,cas_n,we_n}: NOP 0111, ACTIVE 0011, READ 0101, WRITE 0100, PRECHARGE 0010 (sd_a[10]=1), AUTO_REF 0001, LOAD_MODE 0000; every non-command cycle SHALL drive NOP.
REQ-015 States: IDLE, ACT, RCD_WAIT, RW_CMD, BURST, PRE, RP_WAIT, MRS, REF, REF_WAIT.
REQ-016 busy SHALL equal (state!=IDLE) | ref_pend.
REQ-017 In IDLE with busy=0, Act_st[2]=1 SHALL be accepted that cycle; access/direction/address captured internally.
REQ-018 Act_st[2]=1 while busy=1 SHALL be ignored and SHALL pulse cmd_drop for one cycle on the next edge.
REQ-019 Access: ACT issues ACTIVE (ba, row); RCD_WAIT holds max(rcd_c_max,1) cycles after ACTIVE; RW_CMD issues READ/WRITE (ba, col, sd_a[10]=0); BURST lasts burst_max+1 cycles counted from the READ/WRITE edge; then PRE.
REQ-020 Write: sd_doe SHALL be 1 from the WRITE command cycle for exactly burst_max+1 cycles.
REQ-021 Read: rd_valid SHALL be 1 starting max(cas_lat_max,1) cycles after the READ command cycle, for exactly burst_max+1 cycles; PRE SHALL not issue before the last rd_valid cycle.
REQ-022 PRE issues PRECHARGE all; RP_WAIT holds max(rcd_c_max,1) cycles; return to IDLE.
REQ-023 Act_st=110 SHALL go IDLE->PRE->RP_WAIT->IDLE; Act_st=101 SHALL issue LOAD_MODE with sd_a=Add_reg[11:0], sd_ba=0, then 2 NOP cycles, then IDLE.
REQ-024 Refresh timer: 16-bit down counter; at 1 it SHALL reload ref_max and set ref_pend; held when ref_max=0.
REQ-025 In IDLE with ref_pend=1, the sequencer SHALL enter REF (issue AUTO_REF), clear ref_pend, hold REF_WAIT max(ki_max,1) cycles, return to IDLE.
REQ-026 Host Act_st=111 SHALL follow the same REF path and also clear ref_pend.
REQ-027 ref_pend set in the same cycle a host request is accepted: host request proceeds; refresh runs at next IDLE.
REQ-028 Configuration inputs SHALL be sampled at the start of each wait/burst count; changes mid-count SHALL not affect it.

Reset
REQ-029 While Rst_i=1: state IDLE, command NOP (1111 with cs_n=1), sd_ba=0, sd_a=0, sd_doe=0, rd_valid=0, cmd_drop=0, ref_pend=0, refresh counter=16'hFFFF.
REQ-030 Reset asserted mid-burst SHALL force outputs to reset values immediately (asynchronously); no PRECHARGE issued.
REQ-031 After Rst_i deasserts, first command acceptance possible on the first rising edge.

Verification
REQ-032 rcd=2, cas=2, burst_max=3, Act_st=100, write_st=0, Add_reg=0x0031_2345 -> ACTIVE ba=3 row=0x123, READ col=0x45 2 cycles later, rd_valid cycles 2..5 after READ, PRECHARGE, IDLE.
REQ-033 Same config, write_st=1 -> WRITE with sd_doe high 4 cycles from WRITE edge, then PRECHARGE with sd_a[10]=1.
REQ-034 Act_st=101, Add_reg[11:0]=0x032 -> LOAD_MODE, sd_a=0x032, ba=0, busy 3 cycles.
REQ-035 ref_max=16, ki_max=4, no host traffic -> AUTO_REF every 16 cycles after first reload, busy 5 cycles each.
REQ-036 Act_st=100 issued during READ burst -> cmd_drop pulse, burst unaffected; Rst_i pulsed mid-burst -> NOP, rd_valid=0 immediately.

Source files
------------

// File: rtl/sdram_cmd_seq.sv
// SDRAM command sequencer: row access bursts, precharge-all,
// mode register load and auto refresh with an interval timer.
module sdram_cmd_seq (
  input  logic        Clk_i,
  input  logic        Rst_i,
  input  logic [2:0]  Act_st,
  input  logic        write_st,
  input  logic [31:0] Add_reg,
  input  logic [1:0]  rcd_c_max,
  input  logic [1:0]  cas_lat_max,
  input  logic [2:0]  burst_max,
  input  logic [3:0]  ki_max,
  input  logic [15:0] ref_max,
  output logic        sd_cs_n,
  output logic        sd_ras_n,
  output logic        sd_cas_n,
  output logic        sd_we_n,
  output logic [1:0]  sd_ba,
  output logic [11:0] sd_a,
  output logic        sd_doe,
  output logic        rd_valid,
  output logic        busy,
  output logic        cmd_drop
);

  typedef enum logic [3:0] {
    S_IDLE, S_ACT, S_RCD_WAIT, S_RW_CMD, S_BURST,
    S_PRE, S_RP_WAIT, S_MRS, S_REF, S_REF_WAIT
  } state_t;

  localparam logic [3:0] C_NOP = 4'b0111;
  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_RD  = 4'b0101;
  localparam logic [3:0] C_WR  = 4'b0100;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_REF = 4'b0001;
  localparam logic [3:0] C_MRS = 4'b0000;
  localparam logic [3:0] C_DES = 4'b1111;

  state_t      state;
  logic [3:0]  cmd;
  logic        ref_pend;
  logic [15:0] ref_cnt;
  logic [3:0]  cnt;
  logic [3:0]  bcnt;
  logic [1:0]  cas_q;
  logic [2:0]  bm_q;
  logic        wr_q;
  logic [1:0]  ba_q;
  logic [7:0]  col_q;

  logic [1:0]  rcd_eff;
  logic [1:0]  cas_eff;
  logic [3:0]  ki_eff;
  logic [3:0]  bnext;
  logic [3:0]  b_end;
  logic        ref_hit;
  logic        rw_go;
  logic        unused_ok;

  assign rcd_eff = (rcd_c_max == 2'd0) ? 2'd1 : rcd_c_max;
  assign cas_eff = (cas_lat_max == 2'd0) ? 2'd1 : cas_lat_max;
  assign ki_eff  = (ki_max == 4'd0) ? 4'd1 : ki_max;
  assign bnext   = bcnt + 4'd1;
  assign b_end   = wr_q ? {1'b0, bm_q} + 4'd1
                        : {2'b0, cas_q} + {1'b0, bm_q} + 4'd1;
  assign ref_hit = (ref_max != 16'd0) && (ref_cnt == 16'd1);
  assign rw_go   = (state == S_ACT && rcd_eff == 2'd1) ||
                   (state == S_RCD_WAIT && cnt == 4'd1);
  assign busy    = (state != S_IDLE) | ref_pend;
  assign unused_ok = ^Add_reg[31:22];

  assign {sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n} = cmd;

  // Refresh interval timer; reloads and flags a refresh at count 1.
  always_ff @(posedge Clk_i or posedge Rst_i) begin
    if (Rst_i)
      ref_cnt <= 16'hFFFF;
    else if (ref_max != 16'd0)
      ref_cnt <= ref_hit ? ref_max : ref_cnt - 16'd1;
  end

  // Command FSM with registered pins, data strobes and drop pulse.
  always_ff @(posedge Clk_i or posedge Rst_i) begin
    if (Rst_i) begin
      state    <= S_IDLE;
      cmd      <= C_DES;
      sd_ba    <= 2'd0;
      sd_a     <= 12'd0;
      sd_doe   <= 1'b0;
      rd_valid <= 1'b0;
      cmd_drop <= 1'b0;
      ref_pend <= 1'b0;
      cnt      <= 4'd0;
      bcnt     <= 4'd0;
      cas_q    <= 2'd1;
      bm_q     <= 3'd0;
      wr_q     <= 1'b0;
      ba_q     <= 2'd0;
      col_q    <= 8'd0;
    end else begin
      cmd      <= C_NOP;
      sd_ba    <= 2'd0;
      sd_a     <= 12'd0;
      sd_doe   <= 1'b0;
      rd_valid <= 1'b0;
      cmd_drop <= Act_st[2] & busy;
      unique case (state)
        S_IDLE: begin
          if (ref_pend) begin
            state    <= S_REF;
            cmd      <= C_REF;
            ref_pend <= 1'b0;
          end else if (Act_st[2]) begin
            unique case (Act_st[1:0])
              2'b00: begin
                state <= S_ACT;
                cmd   <= C_ACT;
                sd_ba <= Add_reg[21:20];
                sd_a  <= Add_reg[19:8];
                ba_q  <= Add_reg[21:20];
                col_q <= Add_reg[7:0];
                wr_q  <= write_st;
              end
              2'b01: begin
                state <= S_MRS;
                cmd   <= C_MRS;
                sd_a  <= Add_reg[11:0];
                cnt   <= 4'd2;
              end
              2'b10: begin
                state <= S_PRE;
                cmd   <= C_PRE;
                sd_a  <= 12'h400;
              end
              2'b11: begin
                state    <= S_REF;
                cmd      <= C_REF;
                ref_pend <= 1'b0;
              end
            endcase
          end
        end
        S_ACT: begin
          state <= S_RCD_WAIT;
          cnt   <= {2'b0, rcd_eff} - 4'd1;
        end
        S_RCD_WAIT: cnt <= cnt - 4'd1;
        S_RW_CMD, S_BURST: begin
          state    <= S_BURST;
          bcnt     <= bnext;
          sd_doe   <= wr_q && (bnext <= {1'b0, bm_q});
          rd_valid <= !wr_q && (bnext >= {2'b0, cas_q}) &&
                      (bnext <= {2'b0, cas_q} + {1'b0, bm_q});
          if (bnext == b_end) begin
            state <= S_PRE;
            cmd   <= C_PRE;
            sd_a  <= 12'h400;
          end
        end
        S_PRE: begin
          cnt   <= {2'b0, rcd_eff} - 4'd1;
          state <= (rcd_eff == 2'd1) ? S_IDLE : S_RP_WAIT;
        end
        S_RP_WAIT, S_REF_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1)
            state <= S_IDLE;
        end
        S_MRS: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd0)
            state <= S_IDLE;
        end
        S_REF: begin
          cnt   <= ki_eff - 4'd1;
          state <= (ki_eff == 4'd1) ? S_IDLE : S_REF_WAIT;
        end
        default: state <= S_IDLE;
      endcase
      // Entry into the READ/WRITE cycle latches the burst shape.
      if (rw_go) begin
        state  <= S_RW_CMD;
        cmd    <= wr_q ? C_WR : C_RD;
        sd_ba  <= ba_q;
        sd_a   <= {4'h0, col_q};
        sd_doe <= wr_q;
        cas_q  <= cas_eff;
        bm_q   <= burst_max;
        bcnt   <= 4'd0;
      end
      if (ref_hit)
        ref_pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sdram_cmd_seq.sv
// Randomized scoreboard bench for sdram_cmd_seq: the driver predicts
// command/data/drop events per transaction, a monitor pops and compares.
module tb_sdram_cmd_seq;

  logic        clk;
  logic        Rst_i;
  logic [2:0]  Act_st;
  logic        write_st;
  logic [31:0] Add_reg;
  logic [1:0]  rcd_c_max;
  logic [1:0]  cas_lat_max;
  logic [2:0]  burst_max;
  logic [3:0]  ki_max;
  logic [15:0] ref_max;
  logic        sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n;
  logic [1:0]  sd_ba;
  logic [11:0] sd_a;
  logic        sd_doe, rd_valid, busy, cmd_drop;

  sdram_cmd_seq dut (
    .Clk_i(clk), .Rst_i(Rst_i), .Act_st(Act_st), .write_st(write_st),
    .Add_reg(Add_reg), .rcd_c_max(rcd_c_max), .cas_lat_max(cas_lat_max),
    .burst_max(burst_max), .ki_max(ki_max), .ref_max(ref_max),
    .sd_cs_n(sd_cs_n), .sd_ras_n(sd_ras_n), .sd_cas_n(sd_cas_n),
    .sd_we_n(sd_we_n), .sd_ba(sd_ba), .sd_a(sd_a), .sd_doe(sd_doe),
    .rd_valid(rd_valid), .busy(busy), .cmd_drop(cmd_drop)
  );

  typedef struct {
    int         cyc;
    logic [3:0] cmd;
    logic [1:0] ba;
    logic [11:0] a;
  } cmd_t;

  typedef struct {
    int cyc;
    bit wr;
  } dat_t;

  cmd_t cq[$];
  dat_t dq[$];
  int   dropq[$];

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int blo = 0;
  int bhi = -1;
  int t_rcd, t_cas, t_bm, t_ki;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cfg(input bit real_cfg);
    if (real_cfg) begin
      rcd_c_max   = 2'(t_rcd);
      cas_lat_max = 2'(t_cas);
      burst_max   = 3'(t_bm);
      ki_max      = 4'(t_ki);
    end else begin
      rcd_c_max   = 2'($urandom);
      cas_lat_max = 2'($urandom);
      burst_max   = 3'($urandom);
      ki_max      = 4'($urandom);
    end
  endtask

  // Monitor: every presented command, data strobe and drop pulse
  // consumes the oldest prediction of its kind.
  always @(negedge clk) begin : mon
    cmd_t e;
    dat_t f;
    int   d;
    logic [3:0] c;
    if (!Rst_i) begin
      c = {sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n};
      if (!sd_cs_n && c != 4'b0111) begin
        if (cq.size() == 0)
          chk("cmd_unexpected", longint'(c), 64'h7);
        else begin
          e = cq.pop_front();
          chk("cmd_cycle", cyc, e.cyc);
          chk("cmd_fields", longint'({c, sd_ba, sd_a}),
              longint'({e.cmd, e.ba, e.a}));
        end
      end
      if (sd_doe || rd_valid) begin
        if (dq.size() == 0)
          chk("data_unexpected", longint'({sd_doe, rd_valid}), 0);
        else begin
          f = dq.pop_front();
          chk("data_cycle", cyc, f.cyc);
          chk("data_kind", longint'({sd_doe, rd_valid}),
              f.wr ? 64'h2 : 64'h1);
        end
      end
      if (cmd_drop) begin
        if (dropq.size() == 0)
          chk("drop_unexpected", 1, 0);
        else begin
          d = dropq.pop_front();
          chk("drop_cycle", cyc, d);
        end
      end
      chk("busy", longint'(busy), longint'(cyc >= blo && cyc <= bhi));
    end
  end

  // One host transaction issued in the current cycle; predicts its
  // events from the timing rules, then runs until idle plus gap.
  task automatic do_txn(input logic [1:0] op, input bit wr,
                        input logic [31:0] addr, input int rcd,
                        input int cas, input int bm, input int ki,
                        input bit drop_en, input int gap);
    int a, r, c, k, rw, p, idle, d, s1, s2, s3;
    t_rcd = rcd; t_cas = cas; t_bm = bm; t_ki = ki;
    r = (rcd == 0) ? 1 : rcd;
    c = (cas == 0) ? 1 : cas;
    k = (ki == 0) ? 1 : ki;
    a = cyc;
    s1 = -1; s2 = -1; s3 = -1;
    case (op)
      2'b00: begin
        rw = a + 1 + r;
        p = wr ? rw + bm + 1 : rw + c + bm + 1;
        idle = p + r;
        s1 = a + 1; s2 = rw - 1; s3 = p;
        cq.push_back('{a + 1, 4'b0011, addr[21:20], addr[19:8]});
        cq.push_back('{rw, wr ? 4'b0100 : 4'b0101, addr[21:20],
                       {4'h0, addr[7:0]}});
        cq.push_back('{p, 4'b0010, 2'd0, 12'h400});
        for (int i = 0; i <= bm; i++)
          dq.push_back('{wr ? rw + i : rw + c + i, wr});
      end
      2'b01: begin
        idle = a + 4;
        cq.push_back('{a + 1, 4'b0000, 2'd0, addr[11:0]});
      end
      2'b10: begin
        idle = a + 1 + r;
        s1 = a + 1;
        cq.push_back('{a + 1, 4'b0010, 2'd0, 12'h400});
      end
      default: begin
        idle = a + 1 + k;
        s1 = a + 1;
        cq.push_back('{a + 1, 4'b0001, 2'd0, 12'h000});
      end
    endcase
    blo = a + 1;
    bhi = idle - 1;
    d = drop_en ? int'($urandom_range(idle - 1, a + 1)) : -1;
    if (d >= 0) dropq.push_back(d + 1);
    Act_st = {1'b1, op};
    write_st = wr;
    Add_reg = addr;
    drive_cfg(a == s1 || a == s2 || a == s3);
    while (cyc < idle + gap) begin
      tick();
      Act_st = (cyc == d) ? {1'b1, 2'($urandom)} : {1'b0, 2'($urandom)};
      write_st = 1'($urandom);
      Add_reg = $urandom;
      drive_cfg(cyc == s1 || cyc == s2 || cyc == s3);
    end
  endtask

  initial begin : drv
    int a, rw, rc, k, first;
    logic [1:0] op;
    Rst_i = 1'b1;
    Act_st = 3'b000;
    write_st = 1'b0;
    Add_reg = 32'd0;
    rcd_c_max = 2'd2;
    cas_lat_max = 2'd2;
    burst_max = 3'd3;
    ki_max = 4'd1;
    ref_max = 16'd0;
    repeat (3) tick();
    chk("rst_cmd", longint'({sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n}), 64'hF);
    chk("rst_addr", longint'({sd_ba, sd_a}), 0);
    chk("rst_strobes", longint'({sd_doe, rd_valid, cmd_drop, busy}), 0);
    Rst_i = 1'b0;

    do_txn(2'b00, 1'b0, 32'h0031_2345, 2, 2, 3, 1, 1'b0, 1);
    chk("idle_nop", longint'({sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n}), 64'h7);
    do_txn(2'b00, 1'b1, 32'h0031_2345, 2, 2, 3, 1, 1'b1, 0);
    do_txn(2'b01, 1'b0, 32'h0000_0032, 2, 2, 3, 1, 1'b1, 0);
    do_txn(2'b10, 1'b0, 32'h0000_0000, 3, 1, 0, 1, 1'b0, 2);
    do_txn(2'b11, 1'b0, 32'h0000_0000, 1, 1, 0, 5, 1'b1, 0);

    // Read burst interrupted by a late request and then by reset.
    t_rcd = 2; t_cas = 2; t_bm = 7; t_ki = 1;
    drive_cfg(1'b1);
    a = cyc;
    rw = a + 3;
    rc = rw + 2 + 3;
    cq.push_back('{a + 1, 4'b0011, 2'd1, 12'hABC});
    cq.push_back('{rw, 4'b0101, 2'd1, 12'h0DE});
    for (int i = rw + 2; i < rc; i++) dq.push_back('{i, 1'b0});
    dropq.push_back(rw + 4);
    blo = a + 1;
    bhi = rc - 1;
    Act_st = 3'b100;
    write_st = 1'b0;
    Add_reg = 32'h001A_BCDE;
    while (cyc < rc) begin
      tick();
      Act_st = (cyc == rw + 3) ? 3'b100 : 3'b000;
    end
    Rst_i = 1'b1;
    #1;
    chk("midrst_cmd", longint'({sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n}), 64'hF);
    chk("midrst_rdv", longint'({rd_valid, sd_doe, busy}), 0);
    chk("midrst_addr", longint'({sd_ba, sd_a}), 0);
    repeat (2) tick();
    Rst_i = 1'b0;
    do_txn(2'b01, 1'b0, 32'h0000_0032, 2, 2, 3, 1, 1'b0, 0);

    for (int n = 0; n < 40; n++) begin
      op = 2'($urandom);
      do_txn(op, 1'($urandom), $urandom, int'($urandom_range(3, 0)),
             int'($urandom_range(3, 0)), int'($urandom_range(7, 0)),
             int'($urandom_range(15, 0)), 1'($urandom),
             int'($urandom_range(3, 0)));
    end

    // Periodic refresh with no host traffic.
    Rst_i = 1'b1;
    Act_st = 3'b000;
    ref_max = 16'd16;
    t_rcd = 2; t_cas = 2; t_bm = 3; t_ki = 4;
    drive_cfg(1'b1);
    repeat (2) tick();
    Rst_i = 1'b0;
    k = cyc;
    first = k + 65536;
    while (cyc < first - 2) tick();
    for (int j = 0; j < 5; j++) begin
      blo = first + 16 * j - 1;
      bhi = first + 16 * j + 3;
      cq.push_back('{first + 16 * j, 4'b0001, 2'd0, 12'h000});
      repeat (16) tick();
    end
    Rst_i = 1'b1;
    repeat (2) tick();

    chk("cmd_missing", cq.size(), 0);
    chk("data_missing", dq.size(), 0);
    chk("drop_missing", dropq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
